pipe_sched: RTL

- Pipeline stall/flush scheduler for the 5-stage MIPS pipeline.
- Merges three events into one set of IF/ID/EX control enables: load-use hazards, taken-branch flushes, and multi-cycle MULT/DIV occupancy of EX.
- Sits beside the ID stage and drives PC, IF/ID, ID/EX and the bubble mux.
- Owns the MDU cycle counter and a saturating stall-cycle performance counter.

---
 rtl/pipe_sched_if.sv | 41 ++++
 rtl/pipe_sched.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pipe_sched_if.sv
// Bundle between the ID-stage decode logic and the pipeline scheduler.
// The master drives the hazard/decode inputs; the scheduler (slave)
// returns the front-end enables, MDU status and stall counter.
interface pipe_sched_if #(
  parameter int PERF_W = 16
);
  logic [4:0]        ID_EX_rt;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic              ID_EX_memread;
  logic              jmp;
  logic              dst;
  logic              memwrite;
  logic              beq;
  logic              bne;
  logic              branch_taken;
  logic              ex_mdu;
  logic              ex_mdu_op;
  logic              PCwrite;
  logic              IF_IDwrite;
  logic              ctrl;
  logic              ex_hold;
  logic              IF_flush;
  logic              mdu_busy;
  logic              mdu_done;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output ID_EX_rt, rs, rt, ID_EX_memread, jmp, dst, memwrite, beq, bne,
           branch_taken, ex_mdu, ex_mdu_op,
    input  PCwrite, IF_IDwrite, ctrl, ex_hold, IF_flush, mdu_busy, mdu_done,
           stall_cnt
  );

  modport slave (
    input  ID_EX_rt, rs, rt, ID_EX_memread, jmp, dst, memwrite, beq, bne,
           branch_taken, ex_mdu, ex_mdu_op,
    output PCwrite, IF_IDwrite, ctrl, ex_hold, IF_flush, mdu_busy, mdu_done,
           stall_cnt
  );
endinterface

// File: rtl/pipe_sched.sv
// Stall/flush scheduler for the 5-stage MIPS pipeline. Combines load-use
// hazards, taken-branch flushes and multi-cycle MULT/DIV occupancy of EX
// into one set of PC / IF/ID / ID/EX enables. Priority is
// MDU stall > load-use stall > branch flush; a flush never fires while the
// front end is stalled, since ID re-presents the branch afterwards.
module pipe_sched #(
  parameter int MULT_CYC = 4,
  parameter int DIV_CYC  = 32,
  parameter int CNT_W    = 6,
  parameter int PERF_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  pipe_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The start cycle is the first stalled cycle, so the counter is loaded
  // with N-1 and RUN leaves on the cycle it reads 1.
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [PERF_W-1:0]  r_stall_cnt;

  logic               w_lu_raw;
  logic               w_lu;
  logic               w_pcwrite;
  logic               w_ifidwrite;
  logic               w_ctrl;
  logic               w_ex_hold;
  logic               w_if_flush;
  logic               w_mdu_busy;
  logic               w_mdu_done;

  // Saturating increment for the performance counter.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    if (&v) sat_inc = v;
    else    sat_inc = v + PERF_W'(1);
  endfunction

  // Load-use hazard: a load in EX writes a register ID is about to read.
  // Register 0 never carries a dependency; jumps do not read rs.
  always_comb begin
    w_lu_raw = bus.ID_EX_memread && (bus.ID_EX_rt != 5'd0) &&
               (((bus.ID_EX_rt == bus.rs) && !bus.jmp) ||
                ((bus.ID_EX_rt == bus.rt) &&
                 (bus.dst || bus.beq || bus.bne || bus.memwrite)));
    // While EX holds an MDU op the MDU path owns the stall decision.
    w_lu     = w_lu_raw && !bus.ex_mdu;
  end

  // Next-state, MDU counter and control-enable decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pcwrite   = 1'b0;
    w_ifidwrite = 1'b0;
    w_ctrl      = 1'b0;
    w_ex_hold   = 1'b0;
    w_if_flush  = 1'b0;
    w_mdu_busy  = 1'b0;
    w_mdu_done  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (bus.ex_mdu) begin
          w_ex_hold   = 1'b1;
          w_mdu_busy  = 1'b1;
          w_cnt_nxt   = bus.ex_mdu_op ? DIV_LD : MULT_LD;
          w_state_nxt = RUN;
        end else if (!w_lu) begin
          w_pcwrite   = 1'b1;
          w_ifidwrite = 1'b1;
          w_ctrl      = 1'b1;
          w_if_flush  = bus.branch_taken;
        end
      end
      RUN: begin
        // ex_mdu / ex_mdu_op are not looked at: the op length was fixed
        // when the counter was loaded.
        w_ex_hold  = 1'b1;
        w_mdu_busy = 1'b1;
        if (r_cnt == CNT_ONE) w_state_nxt = DONE;
        else                  w_cnt_nxt   = r_cnt - CNT_ONE;
      end
      DONE: begin
        // HI/LO write strobe; the front end runs normally this cycle and a
        // following MDU op is only accepted once back in IDLE.
        w_mdu_done  = 1'b1;
        w_state_nxt = IDLE;
        if (!w_lu) begin
          w_pcwrite   = 1'b1;
          w_ifidwrite = 1'b1;
          w_ctrl      = 1'b1;
          w_if_flush  = bus.branch_taken;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Outputs are held inactive for the whole time reset is asserted.
    if (!rst) begin
      w_pcwrite   = 1'b0;
      w_ifidwrite = 1'b0;
      w_ctrl      = 1'b0;
      w_ex_hold   = 1'b0;
      w_if_flush  = 1'b0;
      w_mdu_busy  = 1'b0;
      w_mdu_done  = 1'b0;
    end
  end

  // State and MDU counter registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Stall-cycle performance counter: every edge with the PC frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (!w_pcwrite) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign bus.PCwrite    = w_pcwrite;
  assign bus.IF_IDwrite = w_ifidwrite;
  assign bus.ctrl       = w_ctrl;
  assign bus.ex_hold    = w_ex_hold;
  assign bus.IF_flush   = w_if_flush;
  assign bus.mdu_busy   = w_mdu_busy;
  assign bus.mdu_done   = w_mdu_done;
  assign bus.stall_cnt  = r_stall_cnt;

endmodule
